// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two requesters share one external combinational ALU. The arbiter runs in
// three steps:
//   1. In IDLE it picks a winner (round-robin on a tie) and registers that
//      requester's operands and opcode.
//   2. In EXEC the ALU evaluates the registered operands. Its result and
//      flags are captured at the end of that cycle.
//   3. In RESP the registered result is held until the owning requester
//      acknowledges it.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req[1:0]                request level per requester
//   i_a0, i_b0, i_op0         requester 0 operands / opcode
//   i_a1, i_b1, i_op1         requester 1 operands / opcode
//   o_gnt[1:0]                one-cycle pulse: operands of requester i captured
//   o_rsp_valid[1:0]          result for requester i is available
//   o_rsp_result, o_rsp_flags registered ALU result and flags {N,Z,C,V}
//   i_rsp_ack[1:0]            requester i consumes its response
//   o_busy                    FSM not in IDLE
//   o_alu_a, o_alu_b, o_alu_op  to the ALU, from the operand registers
//   i_alu_result, i_alu_n/z/c/v from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic [1:0]       i_op0,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    input  logic [1:0]       i_op1,
    output logic [1:0]       o_gnt,
    output logic [1:0]       o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_flags,
    input  logic [1:0]       i_rsp_ack,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_n,
    input  logic             i_alu_z,
    input  logic             i_alu_c,
    input  logic             i_alu_v
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_owner;
    logic             r_last;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [1:0]       r_gnt;
    logic [1:0]       r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;

    logic             w_win;
    logic             w_winner;
    logic             w_owner_ack;

    // Arbitration: a lone requester wins outright; on a tie the requester
    // that was not served last wins.
    always_comb begin
        w_win    = 1'b0;
        w_winner = 1'b0;
        case (i_req)
            2'b01:   begin w_win = 1'b1; w_winner = 1'b0;    end
            2'b10:   begin w_win = 1'b1; w_winner = 1'b1;    end
            2'b11:   begin w_win = 1'b1; w_winner = ~r_last; end
            default: begin w_win = 1'b0; w_winner = 1'b0;    end
        endcase
    end

    // An ack on the non-owner bit is ignored.
    assign w_owner_ack = i_rsp_ack[r_owner];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_win) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (w_owner_ack) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 2'b00;
            r_gnt        <= 2'b00;
            r_rsp_valid  <= 2'b00;
            r_rsp_result <= '0;
            r_rsp_flags  <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            // gnt is a single-cycle pulse coinciding with EXEC.
            r_gnt   <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_win) begin
                        r_owner <= w_winner;
                        r_a     <= w_winner ? i_a1  : i_a0;
                        r_b     <= w_winner ? i_b1  : i_b0;
                        r_op    <= w_winner ? i_op1 : i_op0;
                        r_gnt   <= w_winner ? 2'b10 : 2'b01;
                    end
                end
                S_EXEC: begin
                    r_rsp_result         <= i_alu_result;
                    r_rsp_flags          <= {i_alu_n, i_alu_z, i_alu_c, i_alu_v};
                    r_rsp_valid[r_owner] <= 1'b1;
                end
                S_RESP: begin
                    if (w_owner_ack) begin
                        r_rsp_valid <= 2'b00;
                        r_last      <= r_owner;
                    end
                end
                default: begin
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flags  = r_rsp_flags;
    assign o_busy       = (r_state != S_IDLE);
    assign o_alu_a      = r_a;
    assign o_alu_b      = r_b;
    assign o_alu_op     = r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] a0, b0, a1, b1;
    logic [1:0]   op0, op1;
    logic [1:0]   gnt;
    logic [1:0]   rsp_valid;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [1:0]   rsp_ack;
    logic         busy;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_n, alu_z, alu_c, alu_v;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req),
        .i_a0(a0), .i_b0(b0), .i_op0(op0),
        .i_a1(a1), .i_b1(b1), .i_op1(op1),
        .o_gnt(gnt), .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result),
        .o_rsp_flags(rsp_flags), .i_rsp_ack(rsp_ack), .o_busy(busy),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result),
        .i_alu_n(alu_n), .i_alu_z(alu_z), .i_alu_c(alu_c), .i_alu_v(alu_v)
    );

    // Stand-in for the external ALU: add, sub, and, or with N/Z/C/V.
    logic [W:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (alu_op)
            2'b00: begin
                alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c    = alu_wide[W];
                alu_v    = (alu_a[W-1] == alu_b[W-1]) && (alu_wide[W-1] != alu_a[W-1]);
            end
            2'b01: begin
                alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
                alu_c    = alu_wide[W];
                alu_v    = (alu_a[W-1] != alu_b[W-1]) && (alu_wide[W-1] != alu_a[W-1]);
            end
            2'b10:   alu_wide = {1'b0, alu_a & alu_b};
            default: alu_wide = {1'b0, alu_a | alu_b};
        endcase
        alu_result = alu_wide[W-1:0];
        alu_n      = alu_wide[W-1];
        alu_z      = (alu_wide[W-1:0] == '0);
    end

    typedef struct {
        int         who;
        logic [3:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t sbq[$];
    int   gq[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    logic auto_ack = 1'b0;
    logic [1:0] prev_valid = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: grant pulses and fresh responses are checked against queues.
    initial forever begin
        @(negedge clk);
        if (gnt != 2'b00) begin
            if (gq.size() == 0) chk("unexpected_gnt", 32'(gnt), 32'h0);
            else begin
                int w;
                w = gq.pop_front();
                chk("gnt_order", 32'(gnt), (w == 1) ? 32'h2 : 32'h1);
            end
        end
        if (rsp_valid != 2'b00 && prev_valid == 2'b00) begin
            if (sbq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_owner", 32'(rsp_valid), (e.who == 1) ? 32'h2 : 32'h1);
                chk("rsp_result", 32'(rsp_result), 32'(e.res));
                chk("rsp_flags", 32'(rsp_flags), 32'(e.flg));
            end
        end
        prev_valid = rsp_valid;
    end

    // Optional responder that acks in the first RESP cycle.
    initial forever begin
        @(negedge clk);
        if (auto_ack) rsp_ack = rsp_valid;
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'h0);
    endtask

    // Issue one operation, expecting requester 'who' to win.
    task automatic issue(input logic [1:0] rq, input int who, input logic [3:0] a,
                         input logic [3:0] b, input logic [1:0] op,
                         input logic [3:0] res, input logic [3:0] flg);
        int n;
        if (who == 0) begin a0 = a; b0 = b; op0 = op; end
        else          begin a1 = a; b1 = b; op1 = op; end
        gq.push_back(who);
        sbq.push_back('{who, res, flg});
        req = rq;
        n = 0;
        while (gq.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("gnt_timeout", 32'(gq.size()), 32'h0);
        req = 2'b00;
        wait_drain();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},       32'(gnt),        32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid),  32'h0);
        chk({tag, "_result"},    32'(rsp_result), 32'h0);
        chk({tag, "_flags"},     32'(rsp_flags),  32'h0);
        chk({tag, "_busy"},      32'(busy),       32'h0);
        chk({tag, "_alu_a"},     32'(alu_a),      32'h0);
        chk({tag, "_alu_b"},     32'(alu_b),      32'h0);
        chk({tag, "_alu_op"},    32'(alu_op),     32'h0);
    endtask

    initial begin
        req = 2'b00; rsp_ack = 2'b00;
        a0 = '0; b0 = '0; op0 = 2'b00;
        a1 = '0; b1 = '0; op1 = 2'b00;
        do_reset();
        chk_reset_outputs("por");

        // Single op from requester 0 with exact cycle timing: 3+4=7.
        auto_ack = 1'b1;
        a0 = 4'd3; b0 = 4'd4; op0 = 2'b00;
        gq.push_back(0);
        sbq.push_back('{0, 4'd7, 4'b0000});
        req = 2'b01;
        @(posedge clk); #1 req = 2'b00;
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_busy_exec", 32'(busy), 32'h1);
        chk("t1_novalid_exec", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_result", 32'(rsp_result), 32'h7);
        chk("t1_flags", 32'(rsp_flags), 32'h0);
        chk("t1_gnt_pulse", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_valid_clr", 32'(rsp_valid), 32'h0);
        chk("t1_alu_a_hold", 32'(alu_a), 32'h3);

        // Fairness: req=11 held after reset, grants 0,1,0,1.
        do_reset();
        a0 = 4'd1; b0 = 4'd2; op0 = 2'b00;  // 3
        a1 = 4'd6; b1 = 4'd3; op1 = 2'b10;  // 2
        for (int i = 0; i < 4; i++) begin
            gq.push_back(i % 2);
            if (i % 2 == 0) sbq.push_back('{0, 4'd3, 4'b0000});
            else            sbq.push_back('{1, 4'd2, 4'b0000});
        end
        req = 2'b11;
        for (int i = 0; i < 60 && gq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("rr_gnt_timeout", 32'(gq.size()), 32'h0);
        req = 2'b00;
        wait_drain();

        // Directed ALU cases.
        issue(2'b10, 1, 4'd2, 4'd5, 2'b01, 4'hD, 4'b1000);
        issue(2'b01, 0, 4'd9, 4'd9, 2'b00, 4'h2, 4'b0011);
        issue(2'b01, 0, 4'd5, 4'd5, 2'b01, 4'h0, 4'b0110);

        // Non-owner ack ignored; response held stable.
        auto_ack = 1'b0; rsp_ack = 2'b00;
        a0 = 4'd1; b0 = 4'd1; op0 = 2'b11;
        gq.push_back(0);
        sbq.push_back('{0, 4'd1, 4'b0000});
        req = 2'b01;
        @(posedge clk); #1 req = 2'b00;
        @(posedge clk); #1 rsp_ack = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'h1);
            chk("hold_result", 32'(rsp_result), 32'h1);
        end
        rsp_ack = 2'b01;
        @(posedge clk); #1 rsp_ack = 2'b00;
        chk("hold_released_busy", 32'(busy), 32'h0);
        chk("hold_released_valid", 32'(rsp_valid), 32'h0);

        // Reset during EXEC: no response follows.
        a0 = 4'd1; b0 = 4'd1; op0 = 2'b00;
        gq.push_back(0);
        req = 2'b01;
        @(posedge clk); #1 req = 2'b00; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_outputs("rst_exec");
        repeat (2) @(posedge clk);
        #1 chk("rst_exec_no_rsp", 32'(rsp_valid), 32'h0);

        // Reset during RESP: 7+1 = 8 with N and V.
        a1 = 4'd7; b1 = 4'd1; op1 = 2'b00;
        gq.push_back(1);
        sbq.push_back('{1, 4'd8, 4'b1001});
        req = 2'b10;
        @(posedge clk); #1 req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_resp_valid_pre", 32'(rsp_valid), 32'h2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk_reset_outputs("rst_resp");

        // After reset the first tie goes to requester 0: 4-1=3, C=1.
        auto_ack = 1'b1;
        issue(2'b11, 0, 4'd4, 4'd1, 2'b01, 4'd3, 4'b0010);

        chk("sb_empty", 32'(sbq.size()), 32'h0);
        chk("gq_empty", 32'(gq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU instance between two requesters. Registered operand capture, one-cycle ALU evaluation, a registered result/flag return held until the owning requester acknowledges. Round-robin fairness. Sits between the two command sources in the slave datapath and the `ALU` datapath block. The ALU's `A`, `B`, `opcode`, `result`, `N`, `Z`, `C` and `V` connect directly to this block's `alu_*` ports.

## Interface

- WIDTH, 4, operand/result width; must match the ALU `WIDTH`.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester request level; bit i = requester i.
- a0, b0  in  WIDTH each  requester 0 operands.
- op0  in  2  requester 0 opcode: 00 add, 01 sub, 10 and, 11 or.
- a1, b1  in  WIDTH each  requester 1 operands.
- op1  in  2  requester 1 opcode.
- gnt  out  2  one-hot, one-cycle pulse: operands of requester i were captured.
- rsp_valid  out  2  one-hot: result for requester i is available.
- rsp_result  out  WIDTH  registered ALU result.
- rsp_flags  out  4  registered flags {N,Z,C,V}.
- rsp_ack  in  2  requester i consumes its response.
- busy  out  1  high whenever state is not IDLE.
- alu_a, alu_b  out  WIDTH each  to ALU `A`, `B`; driven from the operand registers.
- alu_op  out  2  to ALU `opcode`; driven from the opcode register.
- alu_result  in  WIDTH  from ALU `result`.
- alu_n, alu_z, alu_c, alu_v  in  1 each  from ALU flags.

## Operation

- FSM states: IDLE, EXEC, RESP. Owner register (1 bit) and last-served pointer `last` (1 bit).
- **IDLE:**
  - req == 00: stay in IDLE.
  - Exactly one bit set: that requester wins.
  - Both bits set: the requester != `last` wins.
  - On a win: latch the winner's a/b/op into the operand registers, set owner, set gnt[owner] for the next cycle, go to EXEC.
- **EXEC:**
  - ALU sees the latched operands.
  - At the end of the cycle, capture alu_result and {alu_n, alu_z, alu_c, alu_v} into rsp_result/rsp_flags.
  - Set rsp_valid[owner] and go to RESP.
- **RESP:**
  - Hold rsp_valid/rsp_result/rsp_flags stable.
  - When rsp_ack[owner] is sampled high: clear rsp_valid, set `last` = owner, go to IDLE.
  - rsp_ack on the non-owner bit is ignored.
- req is only sampled in IDLE. A requester still holding req when the FSM returns to IDLE is treated as a new request. Requesters drop req in or after their gnt cycle.
- A requester dropping req before gnt withdraws the request; no capture occurs.
- Operands and opcode must be stable while req is high and the FSM is in IDLE. After gnt they may change freely.
- Arithmetic and flag semantics are entirely the ALU's. This block only registers them, with no width extension or modification.
- **Reset:** state IDLE, owner 0, `last` 1 (requester 0 wins the first tie). Operand registers 0, gnt 00, rsp_valid 00, rsp_result 0, rsp_flags 0000, busy 0.
  - Reset in any state, including mid-EXEC or mid-RESP, aborts the operation with no response.

## Timing

- Request seen in IDLE at cycle t: gnt pulse and EXEC in cycle t+1; rsp_valid high from cycle t+2.
- Ack sampled at cycle k (k ≥ t+2): rsp_valid low and IDLE at k+1. Earliest next capture is at the end of k+1.
- Maximum throughput is one operation per 3 cycles, achieved with ack in the first RESP cycle.
- gnt is exactly one cycle wide. At most one bit of gnt or rsp_valid is ever set.
- alu_a/alu_b/alu_op change only at the capture edge. Outside EXEC they hold the last captured values.

## Test plan

- Reset, then req=01, a0=3, b0=4, op0=00 for one cycle, ack immediately: gnt=01 at t+1; rsp_valid=01, rsp_result=7, flags=0000 at t+2; idle at t+3.
- After reset, req=11 held continuously with instant acks: grant order 0,1,0,1. Each rsp_result matches that requester's operands.
- Requester 1: a1=2, b1=5, op1=01 -> rsp_result=4'hD, N=1, Z=0, C=0, V=0.
- Requester 0: a0=9, b0=9, op0=00 -> rsp_result=2, C=1, V=1. Then a0=5, b0=5, op0=01 -> rsp_result=0, Z=1.
- In RESP with owner 0, pulse rsp_ack=10: no change. Hold for 5 cycles; rsp_result stays constant. Then rsp_ack=01 -> IDLE next cycle.
- Assert rst in EXEC, then separately in RESP: the next cycle shows all outputs at reset values and no rsp_valid. A subsequent req=11 grants requester 0 first.
